// File: rtl/lbist_misr_ora.sv
// LBIST output response analyzer: folds scan-chain and primary-output data
// into a 32-bit Galois MISR over a fixed number of capture cycles, then
// compares the final signature against a golden value.
module lbist_misr_ora #(
  parameter int                SC_W     = 7,
  parameter int                PO_W     = 256,
  parameter int                MISR_W   = 32,
  parameter logic [MISR_W-1:0] POLY     = 32'h04C11DB7,
  parameter logic [MISR_W-1:0] SEED     = 32'h00000000,
  parameter logic [15:0]       PATTERNS = 16'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic [SC_W-1:0]   sc_din,
  input  logic [PO_W-1:0]   po_din,
  input  logic [MISR_W-1:0] golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  // Input vector is zero-padded up to a whole number of MISR-wide slices.
  localparam int IN_W     = SC_W + PO_W;
  localparam int N_SLICES = (IN_W + MISR_W - 1) / MISR_W;
  localparam int V_W      = N_SLICES * MISR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [MISR_W-1:0]   misr;
  logic [MISR_W-1:0]   misr_next;
  logic [MISR_W-1:0]   fold;
  logic [V_W-1:0]      v;
  logic [15:0]         cnt;
  logic                pass_r;
  logic                load;
  logic                update;
  logic                compare;
  logic                last;

  // Fold the padded input vector into one MISR-wide word by XOR of slices.
  always_comb begin
    v                 = '0;
    v[IN_W-1:0]       = {po_din, sc_din};
    fold              = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      fold = fold ^ v[s*MISR_W +: MISR_W];
    end
  end

  // Galois MISR step: shift left, apply feedback on the outgoing MSB, inject fold.
  always_comb begin
    misr_next = {misr[MISR_W-2:0], 1'b0} ^ (misr[MISR_W-1] ? POLY : '0) ^ fold;
  end

  assign last = (cnt == PATTERNS - 16'd1);

  // State register; rst wins over any simultaneous start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_next = state;
    load       = 1'b0;
    update     = 1'b0;
    compare    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (en) begin
          update = 1'b1;
          if (last) state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        compare    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Signature register, capture counter and latched compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      misr   <= '0;
      cnt    <= '0;
      pass_r <= 1'b0;
    end else if (load) begin
      misr   <= SEED;
      cnt    <= '0;
      pass_r <= 1'b0;
    end else if (update) begin
      misr   <= misr_next;
      cnt    <= cnt + 16'd1;
    end else if (compare) begin
      pass_r <= (misr == golden);
    end
  end

  assign busy      = (state == ST_RUN) || (state == ST_CHECK);
  assign done      = (state == ST_DONE);
  assign pass      = done && pass_r;
  assign signature = misr;

endmodule

// File: tb/tb_lbist_misr_ora.sv
// Self-checking bench for lbist_misr_ora. Four instances with different
// PATTERNS/SEED share data inputs; expected session results go into a
// scoreboard queue and are popped when done rises.
module tb_lbist_misr_ora;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef struct packed {
    logic [31:0] sig;
    logic        pass;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   start_v;
  logic         en;
  logic [6:0]   sc_din;
  logic [255:0] po_din;
  logic [31:0]  golden;

  logic         busy_a [4];
  logic         done_a [4];
  logic         pass_a [4];
  logic [31:0]  sig_a  [4];

  int           sel;
  logic         busy_m, done_m, pass_m;
  logic [31:0]  sig_m;

  int           checks = 0;
  int           errors = 0;
  int           edge_cnt;
  exp_t         sb_q [$];

  always #5 clk = ~clk;

  lbist_misr_ora #(.PATTERNS(16'd1), .SEED(32'h00000000)) u_p1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .en(en), .sc_din(sc_din),
    .po_din(po_din), .golden(golden), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .signature(sig_a[0]));

  lbist_misr_ora #(.PATTERNS(16'd2), .SEED(32'h40000000)) u_p2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .en(en), .sc_din(sc_din),
    .po_din(po_din), .golden(golden), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .signature(sig_a[1]));

  lbist_misr_ora #(.PATTERNS(16'd4), .SEED(32'h00000001)) u_p4 (
    .clk(clk), .rst(rst), .start(start_v[2]), .en(en), .sc_din(sc_din),
    .po_din(po_din), .golden(golden), .busy(busy_a[2]), .done(done_a[2]),
    .pass(pass_a[2]), .signature(sig_a[2]));

  lbist_misr_ora u_def (
    .clk(clk), .rst(rst), .start(start_v[3]), .en(en), .sc_din(sc_din),
    .po_din(po_din), .golden(golden), .busy(busy_a[3]), .done(done_a[3]),
    .pass(pass_a[3]), .signature(sig_a[3]));

  // Route the selected instance's outputs to the checker.
  always_comb begin
    busy_m = busy_a[sel];
    done_m = done_a[sel];
    pass_m = pass_a[sel];
    sig_m  = sig_a[sel];
  end

  // Reference MISR step: scatter every input bit onto its signature bit.
  function automatic logic [31:0] model_step(input logic [31:0] m,
                                             input logic [6:0] sc,
                                             input logic [255:0] po);
    logic [31:0] f;
    logic        b;
    f = '0;
    for (int i = 0; i < 263; i++) begin
      b = (i < 7) ? sc[i] : po[i-7];
      f[i % 32] = f[i % 32] ^ b;
    end
    return (m << 1) ^ (m[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Pulse start for the selected instance; the start edge counts as edge 1.
  task automatic start_pulse(input int s);
    start_v    = '0;
    start_v[s] = 1'b1;
    edge_cnt   = 0;
    tick();
    start_v    = '0;
  endtask

  // Wait (bounded) for done, then pop and compare the scoreboard entry.
  task automatic wait_done(input string tag, input int max_edges);
    exp_t e;
    while (!done_m && edge_cnt < max_edges) tick();
    check({tag, "_done"}, {31'b0, done_m}, 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_sig"}, sig_m, e.sig);
      check({tag, "_pass"}, {31'b0, pass_m}, {31'b0, e.pass});
    end
  endtask

  initial begin
    logic [31:0] m;
    int          updates;
    int          zeros;
    logic        saw_done;
    logic [3:0]  en_pat;

    rst = 1'b1; start_v = '0; en = 1'b0; sc_din = '0; po_din = '0;
    golden = '0; sel = 0; edge_cnt = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'b0, busy_m}, 32'd0);
    check("rst_done", {31'b0, done_m}, 32'd0);
    check("rst_pass", {31'b0, pass_m}, 32'd0);
    check("rst_sig", sig_m, 32'h0);

    // PATTERNS=1, scan chain 0 set.
    sel = 0; en = 1'b1; sc_din = 7'h01; golden = 32'h1;
    sb_q.push_back('{sig: 32'h1, pass: 1'b1});
    start_pulse(0);
    check("p1_busy", {31'b0, busy_m}, 32'd1);
    check("p1_seed", sig_m, 32'h0);
    tick();
    check("p1_capture", sig_m, 32'h1);
    check("p1_not_done", {31'b0, done_m}, 32'd0);
    wait_done("p1", 20);
    check("p1_latency", edge_cnt, 3);

    // Fold mapping: po bit 25 lands on signature bit 0, bit 24 on bit 31.
    sc_din = '0; po_din = '0; po_din[25] = 1'b1; golden = 32'h1;
    sb_q.push_back('{sig: 32'h00000001, pass: 1'b1});
    start_pulse(0);
    wait_done("fold25", 20);
    po_din = '0; po_din[24] = 1'b1; golden = 32'h0;
    sb_q.push_back('{sig: 32'h80000000, pass: 1'b0});
    start_pulse(0);
    wait_done("fold24", 20);

    // Feedback through POLY, then restart from DONE with a wrong golden.
    sel = 1; po_din = '0; golden = 32'h04C11DB7;
    sb_q.push_back('{sig: 32'h04C11DB7, pass: 1'b1});
    start_pulse(1);
    tick();
    check("fb_step1", sig_m, 32'h80000000);
    wait_done("fb_good", 20);
    check("fb_latency", edge_cnt, 4);
    golden = 32'h04C11DB6;
    sb_q.push_back('{sig: 32'h04C11DB7, pass: 1'b0});
    start_pulse(1);
    check("restart_done", {31'b0, done_m}, 32'd0);
    check("restart_pass", {31'b0, pass_m}, 32'd0);
    check("restart_sig", sig_m, 32'h40000000);
    wait_done("fb_bad", 20);

    // en gating 1,0,1,0,1,0,1 with a stray start mid-run.
    sel = 2; golden = 32'h10;
    sb_q.push_back('{sig: 32'h00000010, pass: 1'b1});
    start_pulse(2);
    for (int i = 0; i < 7; i++) begin
      en = (i % 2 == 0);
      if (i == 3) start_v[2] = 1'b1;
      tick();
      start_v = '0;
    end
    en = 1'b1;
    check("gate_sig", sig_m, 32'h10);
    wait_done("gate", 30);
    check("gate_latency", edge_cnt, 9);

    // Full-length random session on default parameters against the model.
    sel = 3; m = 32'h0; updates = 0; zeros = 0;
    start_pulse(3);
    for (int i = 0; i < 4000 && updates < 1024; i++) begin
      en     = ($urandom_range(0, 3) != 0);
      sc_din = 7'($urandom);
      for (int w = 0; w < 8; w++) po_din[w*32 +: 32] = $urandom;
      if (en) begin
        m = model_step(m, sc_din, po_din);
        updates++;
      end else begin
        zeros++;
      end
      tick();
    end
    golden = m;
    sb_q.push_back('{sig: m, pass: 1'b1});
    wait_done("rand", 5000);
    check("rand_latency", edge_cnt, 1024 + 2 + zeros);

    // Reset mid-RUN aborts with no done; rst beats a simultaneous start.
    en = 1'b1;
    start_pulse(3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", {31'b0, busy_m}, 32'd0);
    check("abort_done", {31'b0, done_m}, 32'd0);
    check("abort_pass", {31'b0, pass_m}, 32'd0);
    check("abort_sig", sig_m, 32'h0);
    tick();
    start_v[3] = 1'b1;
    tick();
    rst = 1'b0; start_v = '0;
    check("rst_vs_start_busy", {31'b0, busy_m}, 32'd0);
    check("rst_vs_start_sig", sig_m, 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (done_m || busy_m) saw_done = 1'b1;
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbist_misr_ora.md
# lbist_misr_ora

Output response analyzer for the LBIST controller: the capture-side counterpart of the test-pattern generator. It compacts scan-chain outputs and core primary outputs into a 32-bit multiple-input signature register (MISR) over a programmed number of capture cycles. At the end of the window it compares the signature against a golden value and reports pass/fail. It sits between the scan-chain outputs / core PO boundary and the LBIST control FSM.

## Interface
- SC_W, 7: number of scan chains (width of `sc_din`)
- PO_W, 256: number of core primary outputs observed
- MISR_W, 32: signature width
- POLY, 32'h04C11DB7: MISR feedback polynomial (Galois form, x^32 implicit)
- SEED, 32'h00000000: value loaded into the MISR on `start`
- PATTERNS, 16'd1024: number of compacted cycles per session (valid range ≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a session (accepted in IDLE or DONE only)
- en  in  1  capture qualifier; MISR updates only in RUN with en=1
- sc_din  in  SC_W  scan-chain serial outputs
- po_din  in  PO_W  core primary outputs
- golden  in  MISR_W  expected signature; sampled in CHECK
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  signature==golden; valid while done=1, else 0
- signature  out  MISR_W  current MISR contents

## Operation
- Fold: v = {zero pad, po_din, sc_din} padded to a multiple of MISR_W (default 263→288 bits, 9 slices); sc_din occupies v[SC_W-1:0] and po_din v[SC_W+PO_W-1:SC_W]; fold = XOR of all MISR_W-bit slices of v.
- MISR update: m' = {m[MISR_W-2:0],1'b0} ^ (m[MISR_W-1] ? POLY : 0) ^ fold.
- Capture counter, 16 bits, unsigned; increments only on an update; no wrap within a session.
- FSM:
  - IDLE: start → RUN; m←SEED, cnt←0.
  - RUN: en=1 → update m, cnt++; if cnt==PATTERNS-1 on that update → CHECK. en=0 → hold m and cnt. start is ignored.
  - CHECK: one cycle; pass_r←(m==golden) → DONE. start is ignored.
  - DONE: done=1 and pass=pass_r, held. start → RUN; m←SEED, cnt←0, pass_r←0.
- rst in any state → IDLE; m←0, cnt←0, pass_r←0. This aborts a session in progress with no done pulse.

## Timing
- Reset values: busy=0, done=0, pass=0, signature=32'h0.
- start sampled at edge t → state=RUN and signature=SEED after t; busy=1 from t.
- Each edge in RUN with en=1 applies exactly one update using the sc_din/po_din values present at that edge.
- The PATTERNS-th update occurs at edge u. CHECK follows u, and the compare happens at edge u+1 using golden at u+1. DONE follows u+1: done=1 and pass valid.
- Total latency from the start edge to done=1 is PATTERNS + 2 edges when en is held high. Each en=0 cycle adds one.
- signature is frozen through CHECK and DONE until the next start or rst.
- rst and start in the same cycle: rst wins.

## Test plan
- Reset: assert rst 2 cycles mid-RUN → busy=0, done=0, pass=0, signature=0 next cycle; no done follows.
- PATTERNS=1, SEED=0, en=1, sc_din=7'h01, po_din=0, golden=32'h1, start → signature=32'h00000001 after the capture edge; done=1, pass=1 two edges later.
- Fold mapping: PATTERNS=1, sc_din=0, po_din bit 25=1 (v bit 32 → slice 1 bit 0) → signature=32'h00000001. po_din bit 24 alone → signature=32'h80000000.
- Feedback: PATTERNS=2, SEED=32'h40000000, inputs 0 → 32'h80000000, then 32'h04C11DB7. With golden=32'h04C11DB7, pass=1; with golden=32'h04C11DB6, pass=0 and done=1.
- en gating: PATTERNS=4, en toggling 1,0,1,0,1,0,1 with inputs 0, SEED=1 → final signature=32'h00000010; done rises 9 edges after start; start pulsed during RUN has no effect.
- Restart from DONE: start in DONE → pass=0 and done=0 next cycle, signature=SEED; a second identical session reproduces the identical signature.
